sreg_unmarshalling: RTL
=======================

SREG_UNMARSHALLING -- requirements
Module: sreg_unmarshalling

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1; 1 = bit 0 shifted out first, 0 = bit 7 first.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port byte_in, input, 8, parallel byte to serialize.
REQ-005 SHALL have port byte_valid, input, 1, byte_in holds a byte to send.
REQ-006 SHALL have port byte_ready, output, 1, block accepts byte_in this cycle.
REQ-007 SHALL have port serial_out, output, 1, serial bit stream.
REQ-008 SHALL have port frame_start, output, 1, high while serial_out carries the first bit of a frame.
REQ-009 SHALL have port busy, output, 1, high while a frame is being shifted out.

Function
REQ-010 SHALL transfer a byte on a rising edge where byte_valid and byte_ready are both 1 (accept edge); no transfer otherwise.
REQ-011 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT on accept, SHIFT->SHIFT on accept during the last bit, SHIFT->IDLE at the end of the last bit with no accept.
REQ-012 SHALL load byte_in into an internal shift register on the accept edge; later changes to byte_in SHALL NOT affect the frame.
REQ-013 SHALL present the first bit on serial_out for the full cycle after the accept edge (latency 1), then one bit per cycle.
REQ-014 SHALL send a frame of FRAME_LEN bits, where FRAME_LEN = 8 without parity and 9 with parity (REQ-024).
REQ-015 SHALL count bits with a counter that runs 0..FRAME_LEN-1 and resets to 0 on every accept, with no wrap past FRAME_LEN-1.
REQ-016 SHALL drive byte_ready = 1 in IDLE and in the cycle carrying the last bit of a frame; 0 otherwise; 0 while rst is high.
REQ-017 SHALL support gapless back-to-back frames: on an accept during the last bit, the next frame's first bit SHALL follow immediately in the next cycle.
REQ-018 SHALL drive frame_start = 1 only in the cycle carrying bit index 0.
REQ-019 SHALL drive busy = 1 in every SHIFT cycle and 0 in IDLE.
REQ-020 SHALL hold serial_out = 0 in IDLE.
REQ-021 SHALL treat byte_valid while byte_ready = 0 as a no-op; the producer holds byte_valid and byte_in until accepted.

Reset
REQ-022 SHALL, on any rising edge with rst = 1 (including mid-frame), abort the current frame and enter IDLE: serial_out = 0, frame_start = 0, busy = 0, counter = 0, shift register = 0.
REQ-023 SHALL give rst priority over a simultaneous accept; a byte presented on a reset edge SHALL be dropped.

Configuration
REQ-024 SHALL, when macro SREG_UNMARSHALLING_PARITY_EN is defined, append an even-parity bit (XOR of the 8 data bits) as bit index 8 after the data bits, making FRAME_LEN = 9.
REQ-025 SHALL, when SREG_UNMARSHALLING_PARITY_EN is undefined, use FRAME_LEN = 8 and include no parity logic.

Structure
REQ-026 SHALL place BYTE_W = 8 and the FSM state enum (IDLE, SHIFT) in the shared package sreg_marshalling_pkg, which the deserializer also uses.
REQ-027 SHALL be a single module with no sub-module; parity SHALL be an inline XOR reduction.

Verification
REQ-028 Reset then single byte: byte_in=8'hA5 with one valid pulse, LSB_FIRST=1 -> serial_out 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; frame_start only on cycle 1; busy cycles 1..8; then IDLE with serial_out=0.
REQ-029 Back-to-back: 8'h0F then 8'hF0 with byte_valid held -> second accept on the last-bit cycle of the first frame; 16 contiguous bits 1111000000001111; frame_start high on cycles 1 and 9.
REQ-030 Backpressure: byte_valid held during cycles 2..7 of a frame -> byte_ready=0 and no accept until the last-bit cycle; byte_in changes during the frame do not alter serial_out.
REQ-031 Reset mid-frame: rst pulsed after bit 3 of 8'hFF -> next cycle serial_out=0, busy=0, byte_ready=1; the following byte 8'h01 serializes correctly from bit 0.
REQ-032 PARITY_EN defined: 8'h07 -> 9-bit frame 1,1,1,0,0,0,0,0,1; byte_ready high on the 9th bit only.
REQ-033 LSB_FIRST=0: 8'h80 -> serial_out 1 then seven 0s.

Source files
------------

// File: rtl/sreg_marshalling_pkg.sv
// Shared definitions for the byte serializer/deserializer pair.
// Frame length grows by one parity bit when SREG_UNMARSHALLING_PARITY_EN is defined.
package sreg_marshalling_pkg;

   localparam int BYTE_W = 8;

`ifdef SREG_UNMARSHALLING_PARITY_EN
   localparam int FRAME_LEN = BYTE_W + 1;
`else
   localparam int FRAME_LEN = BYTE_W;
`endif

   localparam int CNT_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } sreg_state_e;

endpackage

// File: rtl/sreg_unmarshalling.sv
// Byte-to-serial shifter with a valid/ready byte input and gapless back-to-back frames.
// Define SREG_UNMARSHALLING_PARITY_EN to append an even-parity bit after the data bits.
import sreg_marshalling_pkg::*;

module sreg_unmarshalling #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              serial_out,
   output logic              frame_start,
   output logic              busy,
   output sreg_state_e       state_o
);

   // Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both 1;
   // the producer holds byte_valid/byte_in steady until that edge, rst drops the transfer.

   sreg_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [FRAME_LEN-1:0] sreg_q, sreg_d;
   logic [FRAME_LEN-1:0] frame_load;
   logic                 last_bit;
   logic                 accept;

   assign last_bit   = (state_q == SHIFT) && (cnt_q == CNT_W'(FRAME_LEN - 1));
   assign byte_ready = !rst && ((state_q == IDLE) || last_bit);
   assign accept     = byte_valid && byte_ready;

   // The frame is laid out in shift order so the outgoing bit is always at one end.
   always_comb begin
`ifdef SREG_UNMARSHALLING_PARITY_EN
      if (LSB_FIRST) frame_load = {^byte_in, byte_in};
      else           frame_load = {byte_in, ^byte_in};
`else
      frame_load = byte_in;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               cnt_d   = '0;
               sreg_d  = frame_load;
            end
         end
         SHIFT: begin
            if (accept) begin
               cnt_d  = '0;
               sreg_d = frame_load;
            end else if (last_bit) begin
               state_d = IDLE;
               cnt_d   = '0;
               sreg_d  = '0;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
      end
   end

   assign busy        = (state_q == SHIFT);
   assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
   assign serial_out  = (state_q == SHIFT) &&
                        (LSB_FIRST ? sreg_q[0] : sreg_q[FRAME_LEN-1]);
   assign state_o     = state_q;

endmodule
